// File: rtl/ets_pkg.sv
// Shared definitions for the ETS count readout path: channel count, word
// width, header magic and the readout FSM state encoding.
package ets_pkg;

    localparam int          NUM_CH    = 8;
    localparam int          DATA_W    = 32;
    localparam logic [15:0] HDR_MAGIC = 16'hA55A;

    // HDR is only reachable when the header word is compiled in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/ets_count_reader.sv
// ets_count_reader: snapshots the eight per-bit sample counters in one
// cycle, clears the counter bank on the same edge, then streams the
// snapshot out one word per handshake, channel 7 first, channel 0 last.
//
// Optional feature macro: ETS_READER_HEADER_EN. When defined, every frame
// starts with a header word {HDR_MAGIC, frame_cnt[15:0]}, where frame_cnt
// counts completed frames since reset and wraps at 16 bits.
//
// Stream handshake: a word transfers on a rising clk edge where
// m_valid && m_ready. Once m_valid is high, m_data/m_last/m_valid hold
// until that transfer; m_valid never depends combinationally on m_ready.
module ets_count_reader
    import ets_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] cnt_in_7,
    input  logic [DATA_W-1:0] cnt_in_6,
    input  logic [DATA_W-1:0] cnt_in_5,
    input  logic [DATA_W-1:0] cnt_in_4,
    input  logic [DATA_W-1:0] cnt_in_3,
    input  logic [DATA_W-1:0] cnt_in_2,
    input  logic [DATA_W-1:0] cnt_in_1,
    input  logic [DATA_W-1:0] cnt_in_0,
    output logic              clr_out,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output state_t            fsm_state
);

    state_t            state;
    logic [2:0]        index;
    logic [DATA_W-1:0] live     [NUM_CH];
    logic [DATA_W-1:0] snapshot [NUM_CH];
    logic              accept;
    logic              xfer;

`ifdef ETS_READER_HEADER_EN
    logic [15:0]       frame_cnt;
`endif

    assign live[7] = cnt_in_7;
    assign live[6] = cnt_in_6;
    assign live[5] = cnt_in_5;
    assign live[4] = cnt_in_4;
    assign live[3] = cnt_in_3;
    assign live[2] = cnt_in_2;
    assign live[1] = cnt_in_1;
    assign live[0] = cnt_in_0;

    // A start only counts in IDLE; the clear goes out in that same cycle so
    // the bank restarts on the capture edge.
    assign accept    = (state == IDLE) && start;
    assign clr_out   = accept;
    assign xfer      = m_valid && m_ready;

    assign m_valid   = (state != IDLE);
    assign busy      = (state != IDLE);
    assign m_last    = (state == SEND) && (index == 3'd0);
    assign fsm_state = state;

    // Output word select from registered state; idle bus reads zero.
    always_comb begin
        m_data = '0;
        case (state)
`ifdef ETS_READER_HEADER_EN
            HDR:     m_data = DATA_W'({HDR_MAGIC, frame_cnt});
`endif
            SEND:    m_data = snapshot[index];
            default: m_data = '0;
        endcase
    end

    // Capture all counters on the accepted start; held for the whole frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) snapshot[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_CH; i++) snapshot[i] <= live[i];
        end
    end

    // Readout FSM: word index, done pulse and (optionally) frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            index <= 3'd7;
            done  <= 1'b0;
`ifdef ETS_READER_HEADER_EN
            frame_cnt <= 16'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        index <= 3'd7;
`ifdef ETS_READER_HEADER_EN
                        state <= HDR;
`else
                        state <= SEND;
`endif
                    end
                end
                HDR: begin
                    if (xfer) state <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        if (index == 3'd0) begin
                            state <= IDLE;
                            index <= 3'd7;
                            done  <= 1'b1;
`ifdef ETS_READER_HEADER_EN
                            frame_cnt <= frame_cnt + 16'd1;
`endif
                        end else begin
                            index <= index - 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
